bounce_generator: RTL and testbench

- Stimulus source for the button debouncer: the transmit-side counterpart that produces a realistic contact-bounce waveform.
- On command, drives a 1-bit output through a pseudo-random burst of toggles for a fixed window, then settles cleanly at the requested level.
- Used in on-chip self-test and in benches to exercise the debouncer and its timer without a physical button.

---
 rtl/bounce_generator.sv | 164 ++++++++++++++++
 tb/tb_bounce_generator.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_generator.sv
// rtl/bounce_generator.sv - contact-bounce waveform source for exercising the button debouncer
//
// On a start request the output is driven through a pseudo-random burst of
// toggles for a fixed window of clk cycles, then settles at the requested level.
//
// Ports:
//   clk           system clock, all state changes on the rising edge
//   reset_n       asynchronous active-low reset
//   start         request a burst (accepted only while idle)
//   target_level  final settled level, sampled together with start
//   bounce_out    emulated button contact (registered)
//   busy          high while a burst is in progress
//   done          one-cycle pulse once bounce_out has settled
//   toggle_count  toggles in the current or last burst, saturating at 255

module bounce_generator #(
   parameter int unsigned BOUNCE_CYCLES = 1000,
   parameter int unsigned MIN_HOLD      = 8,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter logic        IDLE_LEVEL    = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       target_level,
   output logic       bounce_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] toggle_count
);

   localparam int WIN_W  = $clog2(BOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(MIN_HOLD + 1);

   // The settle is forced one edge before the window ends so that bounce_out
   // already shows the target level in the last busy cycle.
   localparam logic [WIN_W-1:0]  WIN_SETTLE = WIN_W'(BOUNCE_CYCLES - 2);
   localparam logic [WIN_W-1:0]  WIN_LAST   = WIN_W'(BOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(MIN_HOLD);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BOUNCE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [15:0]       lfsr;
   logic [15:0]       lfsr_next;
   logic [WIN_W-1:0]  win_cnt;
   logic [WIN_W-1:0]  win_next;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_next;
   logic              target_q;
   logic              target_next;
   logic              out_next;
   logic              busy_next;
   logic              done_next;
   logic [7:0]        count_next;
   logic [7:0]        count_inc;

   // Galois LFSR, x^16+x^14+x^13+x^11+1; free-running from reset release.
   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);

   assign count_inc = (toggle_count == 8'hFF) ? 8'hFF : toggle_count + 8'd1;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = (target_level != bounce_out) ? S_BOUNCE : S_DONE;
            end
         end
         S_BOUNCE: begin
            if (win_cnt == WIN_LAST) begin
               next_state = S_DONE;
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Output and datapath next values; everything is registered below.
   always_comb begin
      out_next    = bounce_out;
      count_next  = toggle_count;
      win_next    = win_cnt;
      hold_next   = hold_cnt;
      target_next = target_q;
      busy_next   = (next_state == S_BOUNCE);
      done_next   = (next_state == S_DONE);

      case (state)
         S_IDLE: begin
            if (start) begin
               target_next = target_level;
               if (target_level != bounce_out) begin
                  out_next   = ~bounce_out;
                  count_next = 8'd1;
                  win_next   = '0;
                  hold_next  = '0;
               end else begin
                  count_next = 8'd0;
               end
            end
         end
         S_BOUNCE: begin
            win_next  = win_cnt + WIN_W'(1);
            hold_next = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + HOLD_W'(1);
            if (win_cnt == WIN_SETTLE) begin
               // Forced settle: ignores hold spacing and toggle parity.
               out_next = target_q;
               if (target_q != bounce_out) begin
                  count_next = count_inc;
               end
            end else if ((win_cnt < WIN_SETTLE) && (hold_cnt >= HOLD_MAX) && lfsr[0]) begin
               out_next   = ~bounce_out;
               hold_next  = '0;
               count_next = count_inc;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr         <= LFSR_SEED;
         win_cnt      <= '0;
         hold_cnt     <= '0;
         target_q     <= IDLE_LEVEL;
         bounce_out   <= IDLE_LEVEL;
         busy         <= 1'b0;
         done         <= 1'b0;
         toggle_count <= 8'd0;
      end else begin
         lfsr         <= lfsr_next;
         win_cnt      <= win_next;
         hold_cnt     <= hold_next;
         target_q     <= target_next;
         bounce_out   <= out_next;
         busy         <= busy_next;
         done         <= done_next;
         toggle_count <= count_next;
      end
   end

endmodule

// File: tb/tb_bounce_generator.sv
// tb/tb_bounce_generator.sv - self-checking bench for bounce_generator

module tb_bounce_generator;

   localparam int BC  = 16;
   localparam int MH  = 2;
   localparam int DEB = 24;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       start = 1'b0;
   logic       target_level = 1'b0;
   logic       bounce_out;
   logic       busy;
   logic       done;
   logic [7:0] toggle_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   bounce_generator #(
      .BOUNCE_CYCLES(BC),
      .MIN_HOLD     (MH),
      .LFSR_SEED    (16'hACE1),
      .IDLE_LEVEL   (1'b0)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .target_level(target_level),
      .bounce_out  (bounce_out),
      .busy        (busy),
      .done        (done),
      .toggle_count(toggle_count)
   );

   // Simple counter debouncer used as the downstream consumer.
   logic deb_out;
   int   deb_cnt;
   int   deb_changes;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_out     <= 1'b0;
         deb_cnt     <= 0;
         deb_changes <= 0;
      end else if (bounce_out == deb_out) begin
         deb_cnt <= 0;
      end else if (deb_cnt == DEB - 1) begin
         deb_out     <= bounce_out;
         deb_cnt     <= 0;
         deb_changes <= deb_changes + 1;
      end else begin
         deb_cnt <= deb_cnt + 1;
      end
   end

   typedef struct {
      logic       s;
      logic       t;
      logic       o;
      logic       b;
      logic       d;
      logic [7:0] c;
      string      name;
   } vec_t;

   vec_t tbl[7];

   function automatic vec_t mk(input logic s, input logic t, input logic o,
                               input logic b, input logic d, input logic [7:0] c,
                               input string name);
      vec_t v;
      v.s = s; v.t = t; v.o = o; v.b = b; v.d = d; v.c = c; v.name = name;
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      start = 1'b0;
      target_level = 1'b0;
      repeat (3) cycle();
      check("reset_out", int'(bounce_out), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_count", int'(toggle_count), 0);
      reset_n = 1'b1;
   endtask

   task automatic apply_vectors(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         start = tbl[i].s;
         target_level = tbl[i].t;
         cycle();
         check({tbl[i].name, "_out"}, int'(bounce_out), int'(tbl[i].o));
         check({tbl[i].name, "_busy"}, int'(busy), int'(tbl[i].b));
         check({tbl[i].name, "_done"}, int'(done), int'(tbl[i].d));
         check({tbl[i].name, "_count"}, int'(toggle_count), int'(tbl[i].c));
      end
      start = 1'b0;
   endtask

   // Cycle c is the c-th sample after the edge that accepts start.
   task automatic run_burst(input logic tgt, input int inject_c, output int cnt_out);
      int   edges;
      int   last_edge;
      logic prev;
      edges = 0;
      last_edge = 0;
      cnt_out = 0;
      prev = bounce_out;
      check("burst_precondition", int'(prev), int'(!tgt));
      start = 1'b1;
      target_level = tgt;
      for (int c = 1; c <= BC + 2; c++) begin
         cycle();
         start = 1'b0;
         target_level = tgt;
         if (bounce_out != prev) begin
            edges++;
            if (edges > 1 && c != BC) check("toggle_spacing_ok", int'(c - last_edge >= MH), 1);
            last_edge = c;
         end
         prev = bounce_out;
         check("busy_window", int'(busy), int'(c <= BC));
         check("done_timing", int'(done), int'(c == BC + 1));
         if (c == 1) check("initial_edge", int'(bounce_out), int'(tgt));
         if (c >= BC) check("settled_level", int'(bounce_out), int'(tgt));
         if (c == BC + 1) begin
            check("count_equals_edges", int'(toggle_count), edges);
            check("count_odd", edges % 2, 1);
            cnt_out = int'(toggle_count);
         end
         if (c == BC + 2) check("count_holds", int'(toggle_count), cnt_out);
         if (c == inject_c) begin
            start = 1'b1;
            target_level = !tgt;
         end
      end
   endtask

   initial begin
      int cnt_a;
      int cnt_b;
      int unused_cnt;

      tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "noop_low");
      tbl[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "idle_after_noop");
      tbl[2] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "noop_again");
      tbl[3] = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "start_in_done_ignored");
      tbl[4] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, "idle_low");
      tbl[5] = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, "noop_high");
      tbl[6] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, "idle_high");

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 50; i++) begin
         cycle();
         check("idle_stable", int'({bounce_out, busy, done, toggle_count}), 0);
      end

      apply_vectors(0, 4);

      // Press burst with an ignored start (target 0) five cycles in.
      run_burst(1'b1, 5, unused_cnt);

      apply_vectors(5, 6);

      run_burst(1'b0, -1, unused_cnt);

      // Reset five cycles into a burst.
      start = 1'b1;
      target_level = 1'b1;
      cycle();
      start = 1'b0;
      repeat (4) cycle();
      check("midburst_busy_before", int'(busy), 1);
      reset_n = 1'b0;
      #1;
      check("midburst_reset_out", int'(bounce_out), 0);
      check("midburst_reset_busy", int'(busy), 0);
      check("midburst_reset_count", int'(toggle_count), 0);
      @(negedge clk);
      repeat (2) cycle();
      reset_n = 1'b1;
      for (int i = 0; i < 30; i++) begin
         cycle();
         check("no_done_after_reset", int'({busy, done}), 0);
      end

      // Integration with the debouncer, then a repeat run for determinism.
      do_reset();
      repeat (7) cycle();
      run_burst(1'b1, -1, cnt_a);
      repeat (40) cycle();
      check("deb_after_press", int'(deb_out), 1);
      check("deb_changes_press", deb_changes, 1);
      run_burst(1'b0, -1, unused_cnt);
      repeat (40) cycle();
      check("deb_after_release", int'(deb_out), 0);
      check("deb_changes_total", deb_changes, 2);

      do_reset();
      repeat (7) cycle();
      run_burst(1'b1, -1, cnt_b);
      check("deterministic_count", cnt_b, cnt_a);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
